// File: rtl/cnn_pkg.sv
// Register map, CTRL/STATUS bit positions and FSM states for the conv/pool engine.
package cnn_pkg;

  localparam int unsigned NumTaps = 9;

  localparam logic [31:0] RegCtrl    = 32'h00;
  localparam logic [31:0] RegStatus  = 32'h04;
  localparam logic [31:0] RegImgW    = 32'h08;
  localparam logic [31:0] RegImgH    = 32'h0C;
  localparam logic [31:0] RegWeight0 = 32'h10;
  localparam logic [31:0] RegWeight8 = 32'h30;
  localparam logic [31:0] RegBias    = 32'h34;
  localparam logic [31:0] RegOutCnt  = 32'h38;

  localparam int unsigned CtrlStart   = 0;
  localparam int unsigned CtrlRelu    = 1;
  localparam int unsigned CtrlPool    = 2;
  localparam int unsigned CtrlClrDone = 3;

  localparam int unsigned StatusBusy = 0;
  localparam int unsigned StatusDone = 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} cnn_state_e;

  function automatic logic is_weight_off(logic [31:0] off);
    return (off >= RegWeight0) && (off <= RegWeight8) && (off[1:0] == 2'b00);
  endfunction

  function automatic logic [3:0] weight_idx(logic [31:0] off);
    return 4'((off - RegWeight0) >> 2);
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// Minimal OBI subordinate types: configuration record plus flat request/response structs.
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_rsp_t;

endpackage

// File: rtl/cnn_line_buffer.sv
// Two raster row stores feeding a sliding 3x3 window; window_o already includes the incoming pixel.
module cnn_line_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_WIDTH  = 64,
  localparam int unsigned CntW      = $clog2(MAX_WIDTH + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clear_i,
  input  logic [CntW-1:0]                     img_w_i,
  input  logic                                pix_fire_i,
  input  logic [DATA_WIDTH-1:0]               pix_data_i,
  output logic [NumTaps-1:0][DATA_WIDTH-1:0]  window_o,
  output logic                                win_valid_o,
  output logic [CntW-1:0]                     col_o,
  output logic [CntW-1:0]                     row_o
);

  localparam int unsigned IdxW = $clog2(MAX_WIDTH);

  logic [DATA_WIDTH-1:0]           mem_top_q [MAX_WIDTH];
  logic [DATA_WIDTH-1:0]           mem_mid_q [MAX_WIDTH];
  logic [2:0][2:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [CntW-1:0]                 col_q, row_q;
  logic [IdxW-1:0]                 idx;

  assign idx = col_q[IdxW-1:0];

  // Tap k = 3*row + col, row 0 oldest line, col 0 oldest column.
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = mem_top_q[idx];
    win_d[1][2] = mem_mid_q[idx];
    win_d[2][2] = pix_data_i;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        window_o[r*3+c] = win_d[r][c];
      end
    end
  end

  assign win_valid_o = (col_q >= CntW'(2)) && (row_q >= CntW'(2));
  assign col_o       = col_q;
  assign row_o       = row_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
        mem_top_q[i] <= '0;
        mem_mid_q[i] <= '0;
      end
    end else if (clear_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pix_fire_i) begin
      win_q          <= win_d;
      mem_top_q[idx] <= mem_mid_q[idx];
      mem_mid_q[idx] <= pix_data_i;
      if (col_q == img_w_i - CntW'(1)) begin
        col_q <= '0;
        row_q <= row_q + CntW'(1);
      end else begin
        col_q <= col_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_pool_engine.sv
// 3x3 convolution with optional ReLU and 2x2 max-pool over a raster pixel stream, OBI-configured.
module conv_pool_engine
  import cnn_pkg::*;
#(
  parameter int unsigned        DATA_WIDTH = 8,
  parameter int unsigned        ACC_WIDTH  = 32,
  parameter int unsigned        MAX_WIDTH  = 64,
  parameter obi_pkg::obi_cfg_t  ObiCfg     = obi_pkg::ObiDefaultConfig,
  parameter type                obi_req_t  = obi_pkg::obi_req_t,
  parameter type                obi_rsp_t  = obi_pkg::obi_rsp_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  obi_req_t              obi_req_i,
  output obi_rsp_t              obi_rsp_o,
  input  logic                  pix_valid_i,
  output logic                  pix_ready_o,
  input  logic [DATA_WIDTH-1:0] pix_data_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [ACC_WIDTH-1:0]  res_data_o,
  output logic                  irq_o
);

  localparam int unsigned CntW     = $clog2(MAX_WIDTH + 1);
  localparam int unsigned PoolN    = MAX_WIDTH / 2;
  localparam int unsigned PoolIdxW = $clog2(PoolN);
  localparam int unsigned AddrW    = ObiCfg.AddrWidth;

  cnn_state_e state_q, state_d;

  logic [31:0]                  img_w_q, img_h_q, out_cnt_q;
  logic signed [DATA_WIDTH-1:0] weight_q [NumTaps];
  logic signed [ACC_WIDTH-1:0]  bias_q;
  logic                         relu_cfg_q, pool_cfg_q, relu_q, pool_q, done_q;
  logic                         rvalid_q, err_q;
  logic [0:0]                   rid_q;
  logic [31:0]                  rdata_q;

  // Register port decode
  logic [AddrW-1:0] addr;
  logic [31:0]      off, rdata_d;
  logic [3:0]       widx;
  logic sel_ctrl, sel_status, sel_imgw, sel_imgh, sel_weight, sel_bias, sel_cnt;
  logic acc_err, wr_en, busy;

  assign addr = obi_req_i.addr[AddrW-1:0];
  assign off  = 32'(addr);
  assign widx = weight_idx(off);

  always_comb begin
    sel_ctrl   = (off == RegCtrl);
    sel_status = (off == RegStatus);
    sel_imgw   = (off == RegImgW);
    sel_imgh   = (off == RegImgH);
    sel_weight = is_weight_off(off);
    sel_bias   = (off == RegBias);
    sel_cnt    = (off == RegOutCnt);
    acc_err = !(sel_ctrl | sel_status | sel_imgw | sel_imgh | sel_weight | sel_bias | sel_cnt)
            || (obi_req_i.we && (sel_status | sel_cnt))
            || (obi_req_i.we && busy && (sel_imgw | sel_imgh | sel_weight | sel_bias));
    rdata_d = '0;
    if (sel_ctrl) begin
      rdata_d[CtrlRelu] = relu_cfg_q;
      rdata_d[CtrlPool] = pool_cfg_q;
    end
    if (sel_status) begin
      rdata_d[StatusBusy] = busy;
      rdata_d[StatusDone] = done_q;
    end
    if (sel_imgw)   rdata_d = img_w_q;
    if (sel_imgh)   rdata_d = img_h_q;
    if (sel_weight) rdata_d = 32'(weight_q[widx]);
    if (sel_bias)   rdata_d = 32'(bias_q);
    if (sel_cnt)    rdata_d = out_cnt_q;
    if (acc_err)    rdata_d = '0;
  end

  assign wr_en = obi_req_i.req && obi_req_i.we && !acc_err;

  logic start_req, start_ok, clr_done, dims_ok;
  assign dims_ok   = (img_w_q >= 32'd3) && (img_w_q <= 32'(MAX_WIDTH))
                  && (img_h_q >= 32'd3) && (img_h_q <= 32'(MAX_WIDTH));
  assign start_req = wr_en && sel_ctrl && obi_req_i.wdata[CtrlStart] && (state_q == StIdle);
  assign start_ok  = start_req && dims_ok;
  assign clr_done  = wr_en && sel_ctrl && obi_req_i.wdata[CtrlClrDone];

  // Pixel pipeline
  logic [NumTaps-1:0][DATA_WIDTH-1:0] window;
  logic                               win_valid, pix_fire, last_pix, res_hs;
  logic [CntW-1:0]                    col, row, cx;
  logic [PoolIdxW-1:0]                pidx;
  logic signed [ACC_WIDTH-1:0]        conv_sum, conv_val, hmax, vmax, out_val;
  logic signed [ACC_WIDTH-1:0]        hold_q, res_data_q;
  logic signed [ACC_WIDTH-1:0]        pool_buf_q [PoolN];
  logic                               emit, res_valid_q;

  cnn_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_WIDTH  (MAX_WIDTH)
  ) u_line_buffer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (start_ok),
    .img_w_i     (img_w_q[CntW-1:0]),
    .pix_fire_i  (pix_fire),
    .pix_data_i  (pix_data_i),
    .window_o    (window),
    .win_valid_o (win_valid),
    .col_o       (col),
    .row_o       (row)
  );

  assign pix_fire = pix_valid_i && pix_ready_o;
  assign res_hs   = res_valid_q && res_ready_i;
  assign last_pix = (col == img_w_q[CntW-1:0] - CntW'(1)) && (row == img_h_q[CntW-1:0] - CntW'(1));
  assign cx       = col - CntW'(2);
  assign pidx     = cx[PoolIdxW:1];

  always_comb begin
    conv_sum = bias_q;
    for (int k = 0; k < NumTaps; k++) begin
      conv_sum = conv_sum
               + ACC_WIDTH'($signed({1'b0, window[k]})) * ACC_WIDTH'(weight_q[k]);
    end
    conv_val = (relu_q && conv_sum[ACC_WIDTH-1]) ? '0 : conv_sum;
    hmax     = (hold_q > conv_val) ? hold_q : conv_val;
    vmax     = (pool_buf_q[pidx] > hmax) ? pool_buf_q[pidx] : hmax;
    // Odd conv column/row of each 2x2 block closes it; trailing odd lines never reach here.
    if (pool_q) begin
      emit    = win_valid && cx[0] && row[0];
      out_val = vmax;
    end else begin
      emit    = win_valid;
      out_val = conv_val;
    end
  end

  // FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StRun;
      StRun:   if (pix_fire && last_pix) state_d = StDrain;
      StDrain: if (!res_valid_q || res_ready_i) state_d = StDone;
      StDone:  if (clr_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy        = (state_q == StRun) || (state_q == StDrain);
    pix_ready_o = (state_q == StRun) && (!res_valid_q || res_ready_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      img_w_q    <= '0;
      img_h_q    <= '0;
      weight_q   <= '{default: '0};
      bias_q     <= '0;
      relu_cfg_q <= 1'b0;
      pool_cfg_q <= 1'b0;
      relu_q     <= 1'b0;
      pool_q     <= 1'b0;
      done_q     <= 1'b0;
      out_cnt_q  <= '0;
    end else begin
      if (wr_en) begin
        if (sel_imgw)   img_w_q <= obi_req_i.wdata;
        if (sel_imgh)   img_h_q <= obi_req_i.wdata;
        if (sel_weight) weight_q[widx] <= obi_req_i.wdata[DATA_WIDTH-1:0];
        if (sel_bias)   bias_q <= ACC_WIDTH'($signed(obi_req_i.wdata));
        if (sel_ctrl) begin
          relu_cfg_q <= obi_req_i.wdata[CtrlRelu];
          pool_cfg_q <= obi_req_i.wdata[CtrlPool];
        end
      end
      if (start_ok) begin
        relu_q <= obi_req_i.wdata[CtrlRelu];
        pool_q <= obi_req_i.wdata[CtrlPool];
      end
      if (start_req)                                   done_q <= !dims_ok;
      else if (clr_done)                               done_q <= 1'b0;
      else if (state_q == StDrain && state_d == StDone) done_q <= 1'b1;
      if (start_req)                      out_cnt_q <= '0;
      else if (res_hs && out_cnt_q != '1) out_cnt_q <= out_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q      <= '0;
      pool_buf_q  <= '{default: '0};
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      if (pix_fire && win_valid && pool_q) begin
        if (!cx[0])       hold_q           <= conv_val;
        else if (!row[0]) pool_buf_q[pidx] <= hmax;
      end
      if (pix_fire && emit) begin
        res_valid_q <= 1'b1;
        res_data_q  <= out_val;
      end else if (res_ready_i) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign irq_o       = done_q;

  // Register port response, one cycle after grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= obi_req_i.req;
      if (obi_req_i.req) begin
        rid_q   <= obi_req_i.aid;
        rdata_q <= rdata_d;
        err_q   <= acc_err;
      end
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = obi_req_i.req;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rid    = rid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.err    = err_q;
  end

  logic unused_sig;
  assign unused_sig = ^{obi_req_i.be, obi_req_i.wdata, cx};

endmodule

// File: doc/conv_pool_engine.md
CONV_POOL_ENGINE -- requirements
Module: conv_pool_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel and weight width (signed weights, unsigned pixels).
REQ-002 SHALL have parameter ACC_WIDTH, default 32: accumulator and result width.
REQ-003 SHALL have parameter MAX_WIDTH, default 64: largest supported image width in pixels, >= 4.
REQ-004 SHALL have parameters ObiCfg (default obi_pkg::ObiDefaultConfig), obi_req_t and obi_rsp_t: OBI subordinate config and types.
REQ-005 clk_i  input  1  sole clock.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 obi_req_i  input  obi_req_t  register-port request.
REQ-008 obi_rsp_o  output  obi_rsp_t  register-port response.
REQ-009 pix_valid_i / pix_ready_o / pix_data_i  in / out / in  1 / 1 / DATA_WIDTH  raster pixel stream.
REQ-010 res_valid_o / res_ready_i / res_data_o  out / in / out  1 / 1 / ACC_WIDTH  signed result stream.
REQ-011 irq_o  output  1  level, high while STATUS.done=1.

Function
REQ-012 Register map SHALL be: 0x00 CTRL (b0 start W1S, b1 relu_en, b2 pool_en, b3 clear_done W1C); 0x04 STATUS RO (b0 busy, b1 done); 0x08 IMG_W; 0x0C IMG_H; 0x10-0x30 WEIGHT0-8 (step 4); 0x34 BIAS; 0x38 OUT_CNT RO.
REQ-013 gnt SHALL equal req combinationally; rvalid SHALL assert exactly one cycle after each granted request, with rid equal to the granted aid.
REQ-014 Unmapped address, write to a RO register, or write to IMG_W/IMG_H/WEIGHT/BIAS while busy SHALL return err=1, rdata=0, and leave state unchanged.
REQ-015 IMG_W or IMG_H outside [3, MAX_WIDTH] at start SHALL leave the engine in IDLE and set done=1 with OUT_CNT=0.
REQ-016 FSM SHALL be IDLE -> RUN on start; RUN -> DRAIN after the last pixel is accepted; DRAIN -> DONE after the last result handshake; DONE -> IDLE on clear_done. Start in any state other than IDLE SHALL be ignored.
REQ-017 pix_ready_o SHALL be 1 only in RUN and only when the output register is empty or res_ready_i=1 in the same cycle.
REQ-018 Conv result SHALL equal BIAS + sum(pixel_k * WEIGHT_k) for each valid 3x3 window. The sum SHALL be sign-extended to ACC_WIDTH and SHALL wrap, with no saturation.
REQ-019 Valid windows SHALL be those with column >= 2 and row >= 2 (0-based). This yields (W-2)x(H-2) conv results; windows never span a row boundary.
REQ-020 relu_en=1 SHALL replace negative conv results with 0 before pooling.
REQ-021 pool_en=1 SHALL emit the max of each non-overlapping 2x2 block of conv results, giving floor((W-2)/2) x floor((H-2)/2) outputs. An odd trailing row or column SHALL be discarded.
REQ-022 A result SHALL appear on res_valid_o 1 cycle after the pixel completing it is accepted. res_data_o SHALL hold stable while res_valid_o=1 and res_ready_i=0.
REQ-023 OUT_CNT SHALL count result handshakes since start, clear on start, and saturate at all-ones.
REQ-024 CTRL relu_en/pool_en SHALL be sampled at start and held for the whole frame.

Reset
REQ-025 Asserting rst_ni SHALL, at any time including mid-frame, return FSM to IDLE and clear all registers, line buffers and pool buffer to 0. It SHALL also drive pix_ready_o, res_valid_o, irq_o, obi_rsp_o.rvalid and obi_rsp_o.gnt-dependent outputs to 0.

Structure
REQ-026 Package cnn_pkg SHALL hold register offsets, CTRL/STATUS bit indices and the FSM state enum.
REQ-027 Sub-module cnn_line_buffer SHALL hold the 2 x MAX_WIDTH row stores plus the 3x3 window and its column/row counters, with runtime width IMG_W.
REQ-028 The pool half-row buffer of MAX_WIDTH/2 entries SHALL reside in conv_pool_engine.

Verification
REQ-029 IMG 4x4, all pixels 1, weights all 1, BIAS 0, relu/pool off -> 4 results of 9, OUT_CNT=4, done=1, irq_o=1.
REQ-030 IMG 4x4, pixels 10, weights all -1, BIAS 5, relu_en=1 -> 4 results of 0. Same frame with relu_en=0 -> 4 results of -85.
REQ-031 IMG 6x6, pixel = raster index 0..35, WEIGHT4=1 and others 0, pool_en=1 -> 4 results: 14, 16, 26, 28.
REQ-032 REQ-029 frame with res_ready_i toggled 1-of-3 cycles -> identical results, pix_ready_o=0 on every stalled cycle, no result lost or duplicated.
REQ-033 Read 0x3C -> err=1, rdata=0. Write IMG_W while busy -> err=1 and value unchanged. Start while busy -> ignored.
REQ-034 Assert rst_ni mid-frame, then rerun REQ-029 -> results identical to the clean run.
